imem_boot_ctrl: RTL and testbench

Boot sequencer for the 5-stage pipeline core. It accepts a valid/ready stream of 32-bit instruction words and writes them byte-wise into instruction memory, MSB byte at the lowest address. A mandatory leading NOP word is inserted at address 0 by the controller itself. The core is held in reset until loading completes plus a fixed hold time, then released.

---
 rtl/boot_pkg.sv | 29 ++
 rtl/imem_boot_ctrl_hold_timer.sv | 27 ++
 rtl/imem_boot_ctrl.sv | 171 +++++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot sequencer.
package boot_pkg;

   typedef enum logic [2:0] {
      IDLE,
      NOP_WR,
      ACCEPT,
      WRITE,
      HOLD,
      RUN,
      ERR
   } boot_state_e;

   localparam int unsigned BYTES_PER_WORD   = 4;
   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

   // Big-endian byte lane: lane 0 is the MSB byte, stored at the lowest address.
   function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/imem_boot_ctrl_hold_timer.sv
// Loadable down-counter with a zero flag; times the core-reset hold interval.
module boot_hold_timer #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero_c
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: writes a forced NOP then a streamed program byte-wise into
// instruction RAM, holds the core in reset until loading plus a hold time ends.
module imem_boot_ctrl
   import boot_pkg::*;
#(
   parameter int unsigned IMEM_BYTES = 256,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned RESET_HOLD = 3,
   parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              core_reset,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-2:0] word_count
);

   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam int unsigned WC_W   = ADDR_W - 1;
   localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

   localparam logic [CNT_W-1:0]  ADDR_FULL = CNT_W'(IMEM_BYTES);
   localparam logic [CNT_W-1:0]  WORD_STEP = CNT_W'(BYTES_PER_WORD);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((RESET_HOLD > 0) ? RESET_HOLD - 1 : 0);

   boot_state_e       state_q, state_d;
   logic [1:0]        byte_q, byte_d;
   logic [CNT_W-1:0]  addr_q, addr_d;
   logic [31:0]       word_q, word_d;
   logic              last_q, last_d;
   logic [WC_W-1:0]   wcount_q, wcount_d;

   logic              hold_load, hold_en, hold_zero_c;

   logic              in_ready_d, wr_en_d, core_reset_d, done_d, error_d;
   logic [ADDR_W-1:0] wr_addr_d;
   logic [7:0]        wr_data_d;

   boot_hold_timer #(.W(HOLD_W)) u_hold (
      .clk      (clk),
      .reset    (reset),
      .load     (hold_load),
      .load_val (HOLD_LOAD),
      .en       (hold_en),
      .zero_c   (hold_zero_c)
   );

   // Next-state logic; outputs are derived from the next state so they register aligned with it.
   always_comb begin
      state_d      = state_q;
      byte_d       = byte_q;
      addr_d       = addr_q;
      word_d       = word_q;
      last_d       = last_q;
      wcount_d     = wcount_q;
      hold_load    = 1'b0;
      hold_en      = 1'b0;
      in_ready_d   = 1'b0;
      wr_en_d      = 1'b0;
      wr_addr_d    = '0;
      wr_data_d    = '0;
      core_reset_d = 1'b1;
      done_d       = 1'b0;
      error_d      = 1'b0;

      case (state_q)
         IDLE, RUN, ERR: begin
            if (start) begin
               state_d  = NOP_WR;
               byte_d   = 2'd0;
               addr_d   = '0;
               wcount_d = '0;
            end
         end
         NOP_WR: begin
            byte_d = byte_q + 2'd1;
            if (byte_q == 2'd3) begin
               state_d  = ACCEPT;
               addr_d   = WORD_STEP;
               wcount_d = WC_W'(1);
            end
         end
         ACCEPT: begin
            if (in_valid && in_ready) begin
               word_d  = in_data;
               last_d  = in_last;
               byte_d  = 2'd0;
               state_d = (addr_q == ADDR_FULL) ? ERR : WRITE;
            end
         end
         WRITE: begin
            byte_d = byte_q + 2'd1;
            if (byte_q == 2'd3) begin
               addr_d   = addr_q + WORD_STEP;
               wcount_d = wcount_q + WC_W'(1);
               if (last_q) begin
                  state_d   = (RESET_HOLD == 0) ? RUN : HOLD;
                  hold_load = 1'b1;
               end else begin
                  state_d = ACCEPT;
               end
            end
         end
         HOLD: begin
            hold_en = 1'b1;
            if (hold_zero_c) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d   = (state_d == ACCEPT);
      core_reset_d = (state_d != RUN);
      done_d       = (state_d == RUN);
      error_d      = (state_d == ERR);
      if (state_d == NOP_WR) begin
         wr_en_d   = 1'b1;
         wr_addr_d = ADDR_W'(byte_d);
         wr_data_d = byte_lane(NOP_WORD, byte_d);
      end else if (state_d == WRITE) begin
         wr_en_d   = 1'b1;
         wr_addr_d = addr_d[ADDR_W-1:0] + ADDR_W'(byte_d);
         wr_data_d = byte_lane(word_d, byte_d);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         byte_q     <= 2'd0;
         addr_q     <= '0;
         word_q     <= '0;
         last_q     <= 1'b0;
         wcount_q   <= '0;
         in_ready   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         core_reset <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
      end else begin
         state_q    <= state_d;
         byte_q     <= byte_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         last_q     <= last_d;
         wcount_q   <= wcount_d;
         in_ready   <= in_ready_d;
         wr_en      <= wr_en_d;
         wr_addr    <= wr_addr_d;
         wr_data    <= wr_data_d;
         core_reset <= core_reset_d;
         done       <= done_d;
         error      <= error_d;
         word_count <= wcount_d;
      end
   end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed, table-driven bench for imem_boot_ctrl using a 16-byte memory so the
// full-memory and overflow boundaries are reached with short programs.
module tb_imem_boot_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       in_valid;
   logic [31:0] in_data;
   logic       in_last;
   logic       in_ready;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       core_reset;
   logic       done;
   logic       error;
   logic [2:0] word_count;

   int n_checks = 0;
   int n_fail   = 0;

   imem_boot_ctrl #(
      .IMEM_BYTES (16),
      .ADDR_W     (4),
      .RESET_HOLD (3),
      .NOP_WORD   (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .core_reset (core_reset),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        boot;
      logic [31:0] data;
      logic        last;
      int unsigned gap;
      logic [3:0]  exp_addr;
      logic [7:0]  exp_b [4];
      logic [2:0]  exp_wc;
      logic        ovf;
   } vec_t;

   function automatic vec_t mk(input logic boot, input logic [31:0] d, input logic l,
                               input int unsigned gap, input logic [3:0] a,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic [2:0] wc, input logic ovf);
      vec_t v;
      v.boot = boot; v.data = d; v.last = l; v.gap = gap; v.exp_addr = a;
      v.exp_b[0] = b0; v.exp_b[1] = b1; v.exp_b[2] = b2; v.exp_b[3] = b3;
      v.exp_wc = wc; v.ovf = ovf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Present one word and wait (bounded) for the handshake edge.
   task automatic send(input logic [31:0] d, input logic l, output logic ok, output int waited);
      ok = 1'b0; waited = 0;
      in_valid = 1'b1; in_data = d; in_last = l;
      while (!ok && waited < 100) begin
         ok = in_ready;
         @(negedge clk);
         waited++;
      end
      in_valid = 1'b0;
   endtask

   // Pulse start and check the four forced NOP bytes at addresses 0..3.
   task automatic boot_and_check_nop();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("boot_core_reset", 32'(core_reset), 32'd1);
      chk("boot_done", 32'(done), 32'd0);
      chk("boot_error", 32'(error), 32'd0);
      chk("boot_word_count", 32'(word_count), 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk("nop_wr_en", 32'(wr_en), 32'd1);
         chk("nop_wr_addr", 32'(wr_addr), 32'(k));
         chk("nop_wr_data", 32'(wr_data), 32'h00);
         chk("nop_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      chk("post_nop_in_ready", 32'(in_ready), 32'd1);
      chk("post_nop_word_count", 32'(word_count), 32'd1);
      chk("post_nop_wr_en", 32'(wr_en), 32'd0);
   endtask

   task automatic apply_vec(input vec_t v);
      logic ok;
      int   waited;
      if (v.boot) boot_and_check_nop();
      for (int g = 0; g < int'(v.gap); g++) begin
         chk("gap_wr_en", 32'(wr_en), 32'd0);
         chk("gap_in_ready", 32'(in_ready), 32'd1);
         @(negedge clk);
      end
      send(v.data, v.last, ok, waited);
      chk("handshake_done", 32'(ok), 32'd1);
      chk("accept_latency", 32'(waited), 32'd1);
      if (v.ovf) begin
         chk("ovf_wr_en", 32'(wr_en), 32'd0);
         chk("ovf_in_ready", 32'(in_ready), 32'd0);
         chk("ovf_word_count", 32'(word_count), 32'(v.exp_wc));
         for (int c = 0; c < 6; c++) begin
            chk("ovf_error", 32'(error), 32'd1);
            chk("ovf_core_reset", 32'(core_reset), 32'd1);
            chk("ovf_done", 32'(done), 32'd0);
            chk("ovf_no_write", 32'(wr_en), 32'd0);
            @(negedge clk);
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            chk("byte_wr_en", 32'(wr_en), 32'd1);
            chk("byte_wr_addr", 32'(wr_addr), 32'(v.exp_addr) + 32'(k));
            chk("byte_wr_data", 32'(wr_data), 32'(v.exp_b[k]));
            chk("byte_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
         end
         chk("word_count", 32'(word_count), 32'(v.exp_wc));
         if (v.last) begin
            for (int c = 1; c <= 4; c++) begin
               if (c > 1) @(negedge clk);
               chk("hold_core_reset", 32'(core_reset), (c < 4) ? 32'd1 : 32'd0);
               chk("hold_done", 32'(done), (c == 4) ? 32'd1 : 32'd0);
               chk("hold_wr_en", 32'(wr_en), 32'd0);
            end
         end else begin
            chk("next_in_ready", 32'(in_ready), 32'd1);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [10];
      logic ok;
      int   waited;

      vecs[0] = mk(1, 32'h0000_2783, 0, 0, 4'd4,  8'h00, 8'h00, 8'h27, 8'h83, 3'd2, 0);
      vecs[1] = mk(0, 32'h0017_8793, 0, 0, 4'd8,  8'h00, 8'h17, 8'h87, 8'h93, 3'd3, 0);
      vecs[2] = mk(0, 32'h0080_056f, 1, 0, 4'd12, 8'h00, 8'h80, 8'h05, 8'h6f, 3'd4, 0);
      vecs[3] = mk(1, 32'h0000_2783, 0, 7, 4'd4,  8'h00, 8'h00, 8'h27, 8'h83, 3'd2, 0);
      vecs[4] = mk(0, 32'h0017_8793, 0, 7, 4'd8,  8'h00, 8'h17, 8'h87, 8'h93, 3'd3, 0);
      vecs[5] = mk(0, 32'h0080_056f, 1, 7, 4'd12, 8'h00, 8'h80, 8'h05, 8'h6f, 3'd4, 0);
      vecs[6] = mk(1, 32'hdead_beef, 0, 0, 4'd4,  8'hde, 8'had, 8'hbe, 8'hef, 3'd2, 0);
      vecs[7] = mk(0, 32'h1234_5678, 0, 0, 4'd8,  8'h12, 8'h34, 8'h56, 8'h78, 3'd3, 0);
      vecs[8] = mk(0, 32'ha5a5_0ff0, 0, 0, 4'd12, 8'ha5, 8'ha5, 8'h0f, 8'hf0, 3'd4, 0);
      vecs[9] = mk(0, 32'hffff_ffff, 1, 0, 4'd0,  8'h00, 8'h00, 8'h00, 8'h00, 3'd4, 1);

      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Idle after reset: core held, nothing written, no start.
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      for (int c = 0; c < 8; c++) begin
         chk("idle_flags", {27'd0, core_reset, wr_en, in_ready, done, error}, 32'b10000);
         @(negedge clk);
      end

      // Basic boot, backpressured re-boot from RUN, then overflow.
      for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

      // Start from ERR clears error and rewrites the NOP.
      boot_and_check_nop();

      // Reset asserted while byte 2 of the second streamed word is on the bus.
      apply_vec(mk(0, 32'h1122_3344, 0, 0, 4'd4, 8'h11, 8'h22, 8'h33, 8'h44, 3'd2, 0));
      send(32'h5566_7788, 1'b0, ok, waited);
      chk("mid_handshake", 32'(ok), 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("mid_byte2_addr", 32'(wr_addr), 32'd10);
      chk("mid_byte2_data", 32'(wr_data), 32'h77);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("mid_rst_flags", {27'd0, core_reset, wr_en, in_ready, done, error}, 32'b10000);
      chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
      chk("mid_rst_word_count", 32'(word_count), 32'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("post_rst_wr_en", 32'(wr_en), 32'd0);
         chk("post_rst_in_ready", 32'(in_ready), 32'd0);
         chk("post_rst_core_reset", 32'(core_reset), 32'd1);
      end

      // Fresh boot after the abort restarts at address 0 and completes.
      apply_vec(mk(1, 32'h0000_006f, 1, 2, 4'd4, 8'h00, 8'h00, 8'h00, 8'h6f, 3'd2, 0));
      @(negedge clk);
      chk("final_done", 32'(done), 32'd1);
      chk("final_core_reset", 32'(core_reset), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
